// File: rtl/pattern_detector_if.sv
//==============================================================================
// Module      : pattern_detector_if
// Description : Serial stream, pattern-load and match-report signals for
//               pattern_detector. The match_count_o signal exists only when
//               PATDET_COUNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pattern_detector_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
);
    logic               ser_in_i;
    logic               ser_valid_i;
    logic               pattern_load_i;
    logic [WIDTH-1:0]   pattern_i;
    logic [WIDTH-1:0]   mask_i;
    logic               overlap_mode_i;
    logic               found_o;
`ifdef PATDET_COUNT_EN
    logic [COUNT_W-1:0] match_count_o;
`endif

    modport master (
        output ser_in_i,
        output ser_valid_i,
        output pattern_load_i,
        output pattern_i,
        output mask_i,
        output overlap_mode_i,
`ifdef PATDET_COUNT_EN
        input  match_count_o,
`endif
        input  found_o
    );

    modport slave (
        input  ser_in_i,
        input  ser_valid_i,
        input  pattern_load_i,
        input  pattern_i,
        input  mask_i,
        input  overlap_mode_i,
`ifdef PATDET_COUNT_EN
        output match_count_o,
`endif
        output found_o
    );

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("pattern_detector_if: WIDTH must be in 2..16");
    end
    if (COUNT_W < 1 || COUNT_W > 16) begin : g_bad_count_w
        $error("pattern_detector_if: COUNT_W must be in 1..16");
    end
endinterface

`default_nettype wire

// File: rtl/pattern_detector.sv
//==============================================================================
// Module      : pattern_detector
// Description : Serial masked pattern detector, overlapping or non-overlapping.
//               Define PATDET_COUNT_EN to add the saturating match counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pattern_detector #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  wire                 clock,
    input  wire                 rst,
    pattern_detector_if.slave   bus
);
    localparam int                 c_FILL_W = $clog2(WIDTH + 1);
    localparam logic [c_FILL_W-1:0] c_FULL  = c_FILL_W'(WIDTH);

    logic [WIDTH-1:0]    hist_q,  hist_d;
    logic [c_FILL_W-1:0] fill_q,  fill_d;
    logic [WIDTH-1:0]    pat_q,   pat_d;
    logic [WIDTH-1:0]    mask_q,  mask_d;
    logic                mode_q,  mode_d;
    logic                found_q, found_d;

    logic [WIDTH:0]      w_shift;
    logic [WIDTH-1:0]    w_hist_next;
    logic [c_FILL_W-1:0] w_fill_inc;
    logic                w_match;
    logic                w_unused_hist_msb;

    // Newest bit lands in bit 0, so the oldest of the window faces pattern[WIDTH-1].
    assign w_shift           = {hist_q, bus.ser_in_i};
    assign w_hist_next       = w_shift[WIDTH-1:0];
    assign w_unused_hist_msb = w_shift[WIDTH];
    assign w_fill_inc        = (fill_q == c_FULL) ? c_FULL : fill_q + 1'b1;

    // Load takes precedence, so a coincident bit can never produce a match.
    assign w_match = bus.ser_valid_i && !bus.pattern_load_i
                     && (w_fill_inc == c_FULL)
                     && (&((w_hist_next ~^ pat_q) | ~mask_q));

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        found_d = w_match;
        if (bus.pattern_load_i) begin
            hist_d = '0;
            fill_d = '0;
            pat_d  = bus.pattern_i;
            mask_d = bus.mask_i;
            mode_d = bus.overlap_mode_i;
        end else if (bus.ser_valid_i) begin
            hist_d = w_hist_next;
            fill_d = (w_match && !mode_q) ? '0 : w_fill_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            mask_q  <= '1;
            mode_q  <= 1'b1;
            found_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            found_q <= found_d;
        end
    end

    assign bus.found_o = found_q;

`ifdef PATDET_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.pattern_load_i) begin
            cnt_d = '0;
        end else if (w_match && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_count_o = cnt_q;
`endif

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("pattern_detector: WIDTH must be in 2..16");
    end
    if (COUNT_W < 1 || COUNT_W > 16) begin : g_bad_count_w
        $error("pattern_detector: COUNT_W must be in 1..16");
    end
endmodule

`default_nettype wire
